// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven instruction fetch with a tagged word FIFO; FETCH_PREFETCH_EN
// selects a 2-deep FIFO (one word ahead), otherwise a 1-deep FIFO.
module fetch_unit #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH-1:0]  pc,
  output logic                   pc_enable,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_addr,
  input  logic                   instr_ready,
  input  logic                   flush,
  input  logic                   halt
);
`ifdef FETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HALTED} state_t;
  state_t                 r_state, w_next;
  logic [1:0]             r_count;
  logic                   r_rp, r_wp;
  logic [ADDR_WIDTH-1:0]  r_addr [2];
  logic [INSTR_WIDTH-1:0] r_word [2];
  logic                   w_push, w_pop;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next  = r_state;
    mem_req = 1'b0;
    case (r_state)
      IDLE:   w_next = FETCH;
      FETCH: begin
        mem_req = (r_count < DEPTH) & !flush & !halt;
        w_next  = halt ? HALTED : FETCH;
      end
      FLUSH:  w_next = FETCH;
      default: w_next = HALTED;
    endcase
    if (flush && r_state != HALTED) w_next = FLUSH;
  end
  assign w_push      = mem_req & mem_ack;
  assign w_pop       = instr_valid & instr_ready & !flush;
  assign pc_enable   = flush | w_push;
  assign mem_addr    = pc;
  assign instr_valid = r_count != 2'd0;
  assign instr       = r_word[r_rp];
  assign instr_addr  = r_addr[r_rp];
  // Two storage slots in both builds; DEPTH only limits how many may be filled.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_count <= 2'd0;
      r_rp    <= 1'b0;
      r_wp    <= 1'b0;
      r_addr  <= '{default: '0};
      r_word  <= '{default: '0};
    end else if (flush) begin
      r_count <= 2'd0;
      r_rp    <= 1'b0;
      r_wp    <= 1'b0;
    end else begin
      if (w_push) begin
        r_addr[r_wp] <= pc;
        r_word[r_wp] <= mem_rdata;
        r_wp         <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a small PC model and
// an address-derived instruction memory.
module tb_fetch_unit;
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  pc, mem_addr, instr_addr, target;
  logic [15:0] mem_rdata, instr;
  logic        pc_enable, mem_req, mem_ack, instr_valid, instr_ready, flush, halt;
  int          n_chk = 0;
  int          n_bad = 0;
  always #5 clock = ~clock;
  assign mem_rdata = {~mem_addr, mem_addr};
  always @(posedge clock or negedge reset_n)
    if (!reset_n) pc <= 8'h00;
    else if (pc_enable) pc <= flush ? target : ((pc + 8'd1) & 8'h7F);
  fetch_unit dut (
    .clock(clock), .reset_n(reset_n), .pc(pc), .pc_enable(pc_enable),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_addr(instr_addr),
    .instr_ready(instr_ready), .flush(flush), .halt(halt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic restart(input logic ack, input logic rdy);
    reset_n     = 1'b0;
    flush       = 1'b0;
    halt        = 1'b0;
    target      = 8'h00;
    mem_ack     = ack;
    instr_ready = rdy;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask
  task automatic next;
    @(negedge clock);
  endtask
  initial begin
    logic [7:0] a;
    int acc;
    logic [7:0] q[$];
    flush = 1'b0; halt = 1'b0; mem_ack = 1'b1; instr_ready = 1'b1; target = 8'h00;
    #12;
    check("rst_req", mem_req, 0);
    check("rst_pcen", pc_enable, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_iaddr", instr_addr, 0);
    // start-up stream
    restart(1'b1, 1'b1);
    check("start_c0_req", mem_req, 0);
`ifdef FETCH_PREFETCH_EN
    for (int i = 1; i <= 3; i++) begin
      next; #1;
      check("start_req", mem_req, 1);
      check("start_addr", mem_addr, i - 1);
      check("start_pcen", pc_enable, 1);
      check("start_valid", instr_valid, i > 1);
      if (i > 1) begin
        a = 8'(i - 2);
        check("start_iaddr", instr_addr, a);
        check("start_instr", instr, {~a, a});
      end
    end
    next; #1;
    check("start_iaddr_last", instr_addr, 2);
`else
    for (int i = 1; i <= 4; i++) begin
      next; #1;
      check("start_req", mem_req, i % 2);
      check("start_pcen", pc_enable, i % 2);
      check("start_valid", instr_valid, 1 - (i % 2));
      if (i % 2 == 1) check("start_addr", mem_addr, (i - 1) / 2);
      else begin
        a = 8'((i - 2) / 2);
        check("start_iaddr", instr_addr, a);
        check("start_instr", instr, {~a, a});
      end
    end
`endif
    // backpressure
    restart(1'b1, 1'b0);
    acc = 0;
    repeat (6) begin
      next; #1;
      acc += int'(pc_enable);
    end
    check("bp_accepts", acc, DEPTH);
    check("bp_pc", pc, DEPTH);
    check("bp_req", mem_req, 0);
    check("bp_iaddr", instr_addr, 0);
    next; instr_ready = 1'b1; #1;
    check("bp_pop_nospace", mem_req, 0);
    check("bp_pop_head", instr_addr, 0);
    next; #1;
    check("bp_resume_req", mem_req, 1);
    check("bp_resume_addr", mem_addr, DEPTH);
    check("bp_resume_valid", instr_valid, DEPTH - 1);
    // slow memory
    restart(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      next; #1;
      check("slow_req", mem_req, 1);
      check("slow_addr", mem_addr, 0);
      check("slow_pcen", pc_enable, 0);
    end
    next; mem_ack = 1'b1; #1;
    check("slow_ack_pcen", pc_enable, 1);
    next; mem_ack = 1'b0; #1;
    check("slow_pcen_after", pc_enable, 0);
    check("slow_valid", instr_valid, 1);
    check("slow_iaddr", instr_addr, 0);
    check("slow_pc", pc, 1);
    // branch with one word buffered and a coincident ack
    restart(1'b1, 1'b0);
    next; #1;
    check("br_c1_req", mem_req, 1);
    next; flush = 1'b1; target = 8'h40; #1;
    check("br_flush_req", mem_req, 0);
    check("br_flush_pcen", pc_enable, 1);
    check("br_flush_valid", instr_valid, 1);
    next; flush = 1'b0; #1;
    check("br_empty", instr_valid, 0);
    check("br_pc", pc, 8'h40);
    check("br_bubble_req", mem_req, 0);
    next; #1;
    check("br_req", mem_req, 1);
    check("br_addr", mem_addr, 8'h40);
    next; #1;
    check("br_valid", instr_valid, 1);
    check("br_iaddr", instr_addr, 8'h40);
    check("br_instr", instr, 16'hBF40);
    // halt with a full FIFO, then reset mid-stream
    restart(1'b1, 1'b0);
    repeat (DEPTH) next;
    next; halt = 1'b1; #1;
    check("halt_req", mem_req, 0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      next; halt = 1'b0; instr_ready = 1'b1; #1;
      check("halt_pop_addr", instr_addr, i);
      check("halt_pop_req", mem_req, 0);
    end
    repeat (3) begin
      next; halt = 1'b0; instr_ready = 1'b0; #1;
      check("halt_last_valid", instr_valid, 1);
      check("halt_last_addr", instr_addr, DEPTH - 1);
      check("halt_hold_req", mem_req, 0);
    end
    #2; reset_n = 1'b0; #1;
    check("halt_async_valid", instr_valid, 0);
    check("halt_async_req", mem_req, 0);
    // address wrap
    restart(1'b1, 1'b1);
    next; flush = 1'b1; target = 8'h7E; #1;
    check("wrap_pcen", pc_enable, 1);
    next; flush = 1'b0; #1;
    check("wrap_pc", pc, 8'h7E);
    repeat (8) begin
      next; #1;
      if (instr_valid) q.push_back(instr_addr);
    end
    check("wrap_count", q.size() >= 3, 1);
    if (q.size() >= 3) begin
      check("wrap_a0", q[0], 8'h7E);
      check("wrap_a1", q[1], 8'h7F);
      check("wrap_a2", q[2], 8'h00);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
